// File: rtl/arb_pkg.sv
// Shared constants for the clk_arb arbiter and its downstream slave-side stages.
package arb_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic SEL_T0 = 1'b0;
  localparam logic SEL_T1 = 1'b1;

endpackage

// File: rtl/arb_sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; one instance per demux target.
module arb_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_arb,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          data,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full when the pointers alias the same slot but sit on different laps.
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk_arb or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk_arb) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= data;
  end

endmodule

// File: rtl/arb_slave_demux.sv
// Slave-side demux for the clk_arb arbiter: routes each accepted word to one of two target FIFOs.
// Optional per-target accepted-word counters are built when ARB_DEMUX_STATS_EN is defined.
module arb_slave_demux #(
  parameter int unsigned DATA_W = arb_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk_arb,
  input  logic                   rst_n,
  input  logic                   s_req,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_sel,
  output logic                   s_ack,
  output logic                   out0_valid,
  output logic [DATA_W-1:0]      out0_data,
  input  logic                   out0_ready,
  output logic                   out1_valid,
  output logic [DATA_W-1:0]      out1_data,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] lvl0,
  output logic [$clog2(DEPTH):0] lvl1
`ifdef ARB_DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1
`endif
);

  import arb_pkg::*;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arb_slave_demux: DEPTH must be a power of two >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("arb_slave_demux: CNT_W must be at least 1");
  end

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  logic accept_c;

  // The pending s_ack masks capture so a request still high during the ack cycle is not written twice.
  always_comb begin
    accept_c = 1'b0;
    if (s_req && !s_ack) begin
      accept_c = (s_sel == SEL_T1) ? ~full1 : ~full0;
    end
  end

  assign push0 = accept_c & (s_sel == SEL_T0);
  assign push1 = accept_c & (s_sel == SEL_T1);
  assign pop0  = out0_ready & ~empty0;
  assign pop1  = out1_ready & ~empty1;

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  always_ff @(posedge clk_arb or negedge rst_n) begin
    if (!rst_n) s_ack <= 1'b0;
    else        s_ack <= accept_c;
  end

  arb_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk_arb (clk_arb),
    .rst_n   (rst_n),
    .push    (push0),
    .pop     (pop0),
    .data    (s_data),
    .head    (out0_data),
    .full    (full0),
    .empty   (empty0),
    .level   (lvl0)
  );

  arb_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk_arb (clk_arb),
    .rst_n   (rst_n),
    .push    (push1),
    .pop     (pop1),
    .data    (s_data),
    .head    (out1_data),
    .full    (full1),
    .empty   (empty1),
    .level   (lvl1)
  );

`ifdef ARB_DEMUX_STATS_EN
  // Saturating accepted-word counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk_arb or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0 && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
      if (push1 && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_arb_slave_demux.sv
// Self-checking bench for arb_slave_demux: directed scenarios plus randomized traffic against a queue model.
module tb_arb_slave_demux;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned LVL_W   = 3;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_arb = 1'b0;
  logic              rst_n   = 1'b0;
  logic              s_req   = 1'b0;
  logic [DATA_W-1:0] s_data  = '0;
  logic              s_sel   = 1'b0;
  logic              s_ack;
  logic              out0_valid, out1_valid;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic              out0_ready = 1'b0;
  logic              out1_ready = 1'b0;
  logic [LVL_W-1:0]  lvl0, lvl1;
`ifdef ARB_DEMUX_STATS_EN
  logic [CNT_W-1:0]  cnt0, cnt1;
`endif

  arb_slave_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_arb    (clk_arb),
    .rst_n      (rst_n),
    .s_req      (s_req),
    .s_data     (s_data),
    .s_sel      (s_sel),
    .s_ack      (s_ack),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .lvl0       (lvl0),
    .lvl1       (lvl1)
`ifdef ARB_DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk_arb = ~clk_arb;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per target, expected ack, saturating counts.
  logic [DATA_W-1:0] q0[$], q1[$];
  bit                m_ack = 1'b0;
  int                m_cnt0 = 0, m_cnt1 = 0;
  logic [DATA_W-1:0] popped0[$], popped1[$];
  int                ack_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ack  = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  task automatic check_all();
    chk("s_ack", 64'(s_ack), 64'(m_ack));
    chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
    chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
    chk("lvl0", 64'(lvl0), 64'(q0.size()));
    chk("lvl1", 64'(lvl1), 64'(q1.size()));
    if (q0.size() != 0) chk("out0_data", 64'(out0_data), 64'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 64'(out1_data), 64'(q1[0]));
`ifdef ARB_DEMUX_STATS_EN
    chk("cnt0", 64'(cnt0), 64'(m_cnt0));
    chk("cnt1", 64'(cnt1), 64'(m_cnt1));
`endif
  endtask

  // One clock: evaluate the model on pre-edge inputs, cross the edge, compare at the falling edge.
  task automatic tick();
    bit                p0, p1, acc, sel;
    logic [DATA_W-1:0] d;
    sel = s_sel;
    d   = s_data;
    p0  = out0_ready && (q0.size() > 0);
    p1  = out1_ready && (q1.size() > 0);
    acc = s_req && !m_ack && ((sel ? q1.size() : q0.size()) < DEPTH);
    if (out0_valid && out0_ready) popped0.push_back(out0_data);
    if (out1_valid && out1_ready) popped1.push_back(out1_data);
    @(posedge clk_arb);
    if (p0) q0.delete(0);
    if (p1) q1.delete(0);
    if (acc) begin
      if (sel) begin
        q1.push_back(d);
        if (m_cnt1 < CNT_MAX) m_cnt1++;
      end else begin
        q0.push_back(d);
        if (m_cnt0 < CNT_MAX) m_cnt0++;
      end
      ack_seen++;
    end
    m_ack = acc;
    @(negedge clk_arb);
    check_all();
  endtask

  // Arbiter-like handshake: hold the request until ack, keep it through the ack cycle, then drop.
  task automatic send(input bit sel, input logic [DATA_W-1:0] d, output int lat);
    lat    = 0;
    s_req  = 1'b1;
    s_sel  = sel;
    s_data = d;
    do begin
      tick();
      lat++;
    end while (!s_ack && lat < 32);
    if (!s_ack) chk("send_timeout", 64'(s_ack), 64'd1);
    tick();
    s_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    while ((out0_valid || out1_valid) && n < 32) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(out0_valid | out1_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int thr0, thr1;
    bit drop;

    repeat (2) @(negedge clk_arb);
    check_all();
    rst_n = 1'b1;
    @(negedge clk_arb);
    check_all();

    // Single write after reset.
    send(1'b0, 32'hA5A5_0001, lat);
    chk("t1_latency", 64'(lat), 64'd1);
    chk("t1_out0_data", 64'(out0_data), 64'hA5A5_0001);
    chk("t1_lvl0", 64'(lvl0), 64'd1);
    chk("t1_out1_valid", 64'(out1_valid), 64'd0);

    // Fill FIFO1, then show the pop edge does not admit the blocked push.
    out1_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b1, DATA_W'(i), lat);
    chk("t2_lvl1_full", 64'(lvl1), 64'd4);
    s_req  = 1'b1;
    s_sel  = 1'b1;
    s_data = 32'd5;
    repeat (3) begin
      tick();
      chk("t2_blocked_ack", 64'(s_ack), 64'd0);
    end
    out1_ready = 1'b1;
    tick();
    chk("t2_pop_edge_ack", 64'(s_ack), 64'd0);
    chk("t2_pop_edge_lvl1", 64'(lvl1), 64'd3);
    chk("t2_new_head", 64'(out1_data), 64'd2);
    out1_ready = 1'b0;
    tick();
    chk("t2_retry_ack", 64'(s_ack), 64'd1);
    chk("t2_retry_lvl1", 64'(lvl1), 64'd4);
    tick();
    s_req = 1'b0;

    // Interleaved targets with both readies high.
    drain();
    popped0.delete();
    popped1.delete();
    ack_seen = 0;
    send(1'b0, 32'd10, lat);
    send(1'b1, 32'd20, lat);
    send(1'b0, 32'd30, lat);
    send(1'b1, 32'd40, lat);
    repeat (3) tick();
    chk("t3_ack_count", 64'(ack_seen), 64'd4);
    chk("t3_n0", 64'(popped0.size()), 64'd2);
    chk("t3_n1", 64'(popped1.size()), 64'd2);
    if (popped0.size() == 2) begin
      chk("t3_out0_first", 64'(popped0[0]), 64'd10);
      chk("t3_out0_second", 64'(popped0[1]), 64'd30);
    end
    if (popped1.size() == 2) begin
      chk("t3_out1_first", 64'(popped1[0]), 64'd20);
      chk("t3_out1_second", 64'(popped1[1]), 64'd40);
    end

    // Simultaneous push and pop on FIFO0.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 32'hB1, lat);
    send(1'b0, 32'hB2, lat);
    chk("t4_lvl0_pre", 64'(lvl0), 64'd2);
    out0_ready = 1'b1;
    s_req  = 1'b1;
    s_sel  = 1'b0;
    s_data = 32'hB3;
    tick();
    chk("t4_ack", 64'(s_ack), 64'd1);
    chk("t4_lvl0_same", 64'(lvl0), 64'd2);
    chk("t4_head", 64'(out0_data), 64'hB2);
    out0_ready = 1'b0;
    tick();
    s_req = 1'b0;
    chk("t4_head_hold", 64'(out0_data), 64'hB2);

    // Reset mid-operation with lvl0=3 and an ack pending.
    s_req  = 1'b1;
    s_sel  = 1'b0;
    s_data = 32'hC1;
    tick();
    chk("t5_pre_lvl0", 64'(lvl0), 64'd3);
    chk("t5_pre_ack", 64'(s_ack), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", 64'(s_ack), 64'd0);
    chk("t5_rst_v0", 64'(out0_valid), 64'd0);
    chk("t5_rst_v1", 64'(out1_valid), 64'd0);
    chk("t5_rst_lvl0", 64'(lvl0), 64'd0);
    chk("t5_rst_lvl1", 64'(lvl1), 64'd0);
    model_reset();
    s_req = 1'b0;
    @(negedge clk_arb);
    @(negedge clk_arb);
    rst_n = 1'b1;
    check_all();
    send(1'b0, 32'hA5A5_0001, lat);
    chk("t5_latency", 64'(lat), 64'd1);
    chk("t5_out0_data", 64'(out0_data), 64'hA5A5_0001);
    chk("t5_lvl0", 64'(lvl0), 64'd1);
    chk("t5_out1_valid", 64'(out1_valid), 64'd0);

`ifdef ARB_DEMUX_STATS_EN
    out0_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b0, DATA_W'(32'hD0 + i), lat);
    chk("t6_cnt0_sat", 64'(cnt0), 64'(CNT_MAX));
    chk("t6_cnt1", 64'(cnt1), 64'd0);
`endif

    // Randomized traffic with drifting consumer throughput.
    drop = 1'b0;
    thr0 = 50;
    thr1 = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        thr0 = int'($urandom_range(0, 100));
        thr1 = int'($urandom_range(0, 100));
      end
      out0_ready = (int'($urandom_range(0, 99)) < thr0);
      out1_ready = (int'($urandom_range(0, 99)) < thr1);
      if (s_req && s_ack) begin
        drop = 1'b1;
      end else if (s_req && !drop) begin
        // request held until acknowledged
      end else begin
        drop   = 1'b0;
        s_req  = ($urandom_range(0, 2) != 0);
        s_sel  = 1'($urandom_range(0, 1));
        s_data = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
